// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, key-size encoding, inverse S-box and GF(2^8) helpers
package aes_pkg;
  typedef enum logic [1:0] {KS_128 = 2'b00, KS_192 = 2'b01, KS_256 = 2'b10} key_size_e;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [15:0] IMC_COEF = 16'hebd9;
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    return ks == KS_128 ? NR_128 : ks == KS_192 ? NR_192 : NR_256;
  endfunction

  // byte x sits at bit offset 2047-8x, i.e. {~x,3'b111}
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      p = c[i] ? p ^ t : p;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [3:0] imc_coef(input int k);
    return IMC_COEF[15 - 4 * (k & 3) -: 4];
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; InvMixColumns bypassed on the last round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] result
);
  logic [127:0] sb, ark, mc;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[127 - 8 * (4 * c + r) -: 8] = inv_sbox(state[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
      assign mc[127 - 8 * (4 * c + r) -: 8] =
        gmul(ark[127 - 32 * c -: 8], imc_coef(0 - r)) ^ gmul(ark[119 - 32 * c -: 8], imc_coef(1 - r)) ^
        gmul(ark[111 - 32 * c -: 8], imc_coef(2 - r)) ^ gmul(ark[103 - 32 * c -: 8], imc_coef(3 - r));
    end
  end
  assign ark = sb ^ rk;
  assign result = last ? ark : mc;
endmodule

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128/192/256 inverse cipher, one round per clock, key-size HEX display
// HEX decode is built only when DECRYPT_HEX_EN is defined; otherwise the digits are blank.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  in,
  output logic [127:0]  out,
  input  logic [1919:0] expanded_key,
  input  logic [1:0]    switch,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX2,
  output logic [6:0]    HEX3
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN = 1'b1;
  logic fsm, fresh, load;
  logic [127:0] state_q, in_q, rk, rnd_out;
  logic [3:0] rnd, rk_idx;
  logic [1:0] sw_q;
  assign load = fsm == S_IDLE && (fresh || in != in_q || switch != sw_q);
  assign rk_idx = fsm == S_IDLE ? nr_of(switch) : rnd;
  assign rk = expanded_key[11'd1919 - {rk_idx, 7'd0} -: 128];
  aes_inv_round u_round (
    .state (state_q),
    .rk    (rk),
    .last  (rnd == 4'd0),
    .result(rnd_out)
  );
  // fresh forces a load after reset even when in/switch match the cleared shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      fresh <= 1'b1;
      state_q <= '0;
      in_q <= '0;
      sw_q <= '0;
      rnd <= '0;
      out <= '0;
    end else if (fsm == S_IDLE) begin
      if (load) begin
        in_q <= in;
        sw_q <= switch;
        state_q <= in ^ rk;
        rnd <= rk_idx - 4'd1;
        fresh <= 1'b0;
        fsm <= S_RUN;
      end
    end else if (rnd != 4'd0) begin
      state_q <= rnd_out;
      rnd <= rnd - 4'd1;
    end else begin
      out <= rnd_out;
      fsm <= S_IDLE;
    end
  end
`ifdef DECRYPT_HEX_EN
  assign HEX3 = switch == KS_128 || switch == KS_192 ? SEG_1 : SEG_2;
  assign HEX2 = switch == KS_128 ? SEG_2 : switch == KS_192 ? SEG_9 : SEG_5;
  assign HEX1 = switch == KS_128 ? SEG_8 : switch == KS_192 ? SEG_2 : SEG_6;
`else
  assign HEX3 = 7'b1111111;
  assign HEX2 = 7'b1111111;
  assign HEX1 = 7'b1111111;
`endif
endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: known-answer vectors plus forward-cipher model scoreboard for aes_decrypt
module tb_aes_decrypt;
  typedef struct {
    logic [1:0]    sw;
    int            nr;
    logic [1919:0] ek;
    logic [127:0]  ct;
    logic [127:0]  pt;
    logic [20:0]   hex;
  } vec_t;
  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
`ifdef DECRYPT_HEX_EN
  localparam logic [20:0] H_128 = {7'b1111001, 7'b0100100, 7'b0000000};
  localparam logic [20:0] H_192 = {7'b1111001, 7'b0010000, 7'b0100100};
  localparam logic [20:0] H_256 = {7'b0100100, 7'b0010010, 7'b0000010};
`else
  localparam logic [20:0] H_128 = {21{1'b1}};
  localparam logic [20:0] H_192 = {21{1'b1}};
  localparam logic [20:0] H_256 = {21{1'b1}};
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] in = '0;
  logic [127:0] out;
  logic [1919:0] ek = '0;
  logic [1:0] sw = '0;
  logic [6:0] hex1, hex2, hex3;
  logic [7:0] sbt [256];
  exp_t q[$];
  exp_t e;
  logic [127:0] last = '0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_decrypt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .out         (out),
    .expanded_key(ek),
    .switch      (sw),
    .HEX1        (hex1),
    .HEX2        (hex2),
    .HEX3        (hex3)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, x);
    if (x == 8'h00) v = 8'h00;
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  // all 60 words are generated so unused slots hold deterministic, non-zero keys
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] r;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i - nk] ^ t;
    end
    for (int i = 0; i < 60; i++) r[1919 - 32 * i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [1919:0] k, input int nr);
    logic [127:0] s, n, m;
    logic [7:0] acc;
    logic [7:0] f [4];
    f = '{8'h02, 8'h03, 8'h01, 8'h01};
    s = p ^ k[1919 -: 128];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          n[127 - 8 * (4 * c + r) -: 8] = sbt[s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]];
      m = n;
      if (rd < nr)
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc ^= gm(n[127 - 8 * (4 * c + j) -: 8], f[(j - r + 4) % 4]);
            m[127 - 8 * (4 * c + r) -: 8] = acc;
          end
      s = m ^ k[1919 - 128 * rd -: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
  endtask

  task automatic push(input logic [127:0] p, input int due);
    exp_t x;
    x.pt = p;
    x.due = due;
    q.push_back(x);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int due;
    sw = v.sw;
    ek = v.ek;
    in = v.ct;
    due = cyc + 1 + v.nr;
    push(v.pt, due);
    #1;
    chk("hex", {hex3, hex2, hex1}, v.hex);
    wait_to(due);
  endtask

  // scoreboard: out must match the queued plaintext on its due edge and hold otherwise
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("result", out, e.pt);
      last = e.pt;
    end else chk("hold", out, last);
  end

  initial begin
    vec_t v [4];
    logic [1919:0] ek128, ek192, ek256;
    logic [127:0] pa, pb, pc, pd, pe, pf, ct;
    int l;
    for (int i = 0; i < 256; i++) sbt[i] = fwd_sbox(8'(i));
    ek128 = expand(KEY, 4);
    ek192 = expand(KEY, 6);
    ek256 = expand(KEY, 8);
    v[0] = '{2'b10, 14, ek256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, H_256};
    v[1] = '{2'b01, 12, ek192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, H_192};
    v[2] = '{2'b00, 10, ek128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, H_128};
    v[3] = '{2'b11, 14, ek256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, H_256};
    repeat (2) @(negedge clk);
    chk("reset_out", out, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(v[i]);
    // input changes mid-run, then again right before a final round
    pa = rnd128();
    pb = rnd128();
    pc = rnd128();
    sw = 2'b10;
    ek = ek256;
    in = encrypt(pa, ek256, 14);
    l = cyc + 1;
    push(pa, l + 14);
    wait_to(l + 5);
    in = encrypt(pb, ek256, 14);
    push(pb, l + 29);
    wait_to(l + 28);
    in = encrypt(pc, ek256, 14);
    push(pc, l + 44);
    wait_to(l + 44);
    // switch change mid-run keeps the captured key size
    pd = rnd128();
    pe = rnd128();
    sw = 2'b01;
    ek = ek192;
    in = encrypt(pd, ek192, 12);
    l = cyc + 1;
    push(pd, l + 12);
    wait_to(l + 3);
    sw = 2'b11;
    in = encrypt(pe, ek192, 14);
    #1;
    chk("hex_live", {hex3, hex2, hex1}, H_256);
    push(pe, l + 27);
    wait_to(l + 27);
    // asynchronous reset in the middle of a run
    pf = rnd128();
    sw = 2'b10;
    ek = ek256;
    ct = encrypt(pf, ek256, 14);
    in = ct;
    l = cyc + 1;
    push(pf, l + 14);
    wait_to(l + 7);
    rst_n = 1'b0;
    q.delete();
    last = '0;
    #1;
    chk("rst_out", out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    l = cyc + 1;
    push(pf, l + 14);
    wait_to(l + 16);
    chk("drain", 128'(q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
